// File: rtl/prbs_checker_multilane_if.sv
// Bus bundle for prbs_checker_multilane: control/rx inputs and counter readout.
// Macro PRBS_CHECKER_PER_LANE_EN adds the per-lane error counter vector.
interface prbs_checker_multilane_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned W      = 16,
  parameter int unsigned NLANES = 4,
  parameter int unsigned CNT_W  = 64
);
  logic [1:0]          mode;
  logic [N-1:0]        eqn;
  logic [NLANES-1:0]   lane_en;
  logic                rx_valid;
  logic [NLANES*W-1:0] rx_bits;
  logic [NLANES-1:0]   lane_locked;
  logic [CNT_W-1:0]    err_bits;
  logic [CNT_W-1:0]    total_bits;
  logic                running;
`ifdef PRBS_CHECKER_PER_LANE_EN
  logic [NLANES*32-1:0] lane_err_bits;

  modport master (
    output mode, eqn, lane_en, rx_valid, rx_bits,
    input  lane_locked, err_bits, total_bits, running, lane_err_bits
  );
  modport slave (
    input  mode, eqn, lane_en, rx_valid, rx_bits,
    output lane_locked, err_bits, total_bits, running, lane_err_bits
  );
`else
  modport master (
    output mode, eqn, lane_en, rx_valid, rx_bits,
    input  lane_locked, err_bits, total_bits, running
  );
  modport slave (
    input  mode, eqn, lane_en, rx_valid, rx_bits,
    output lane_locked, err_bits, total_bits, running
  );
`endif
endinterface

// File: rtl/prbs_checker_multilane.sv
// Multi-lane self-synchronising PRBS checker with lock FSMs and saturating counters.
// Optional macro PRBS_CHECKER_PER_LANE_EN adds per-lane 32-bit error counters.
module prbs_checker_multilane #(
  parameter int unsigned N        = 32,
  parameter int unsigned W        = 16,
  parameter int unsigned NLANES   = 4,
  parameter int unsigned LOCK_CYC = 8,
  parameter int unsigned CNT_W    = 64
) (
  input logic clk,
  input logic rst,
  prbs_checker_multilane_if.slave bus
);
  typedef enum logic [1:0] {ModeReset, ModeAlign, ModeRun, ModeFreeze} mode_e;
  typedef enum logic {StUnlocked, StLocked} lock_e;

  localparam int unsigned FillW = $clog2(N + 1);
  localparam int unsigned LockW = $clog2(LOCK_CYC + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(N);
  localparam logic [LockW-1:0] LockDone = LockW'(LOCK_CYC);

  mode_e            mode_q;
  logic [N-1:0]     hist_q [NLANES];
  logic [N-1:0]     hist_d [NLANES];
  logic [FillW-1:0] fill_q [NLANES];
  logic [FillW-1:0] fill_d [NLANES];
  logic [LockW-1:0] lcnt_q [NLANES];
  logic [LockW-1:0] lcnt_d [NLANES];
  lock_e            lock_q [NLANES];
  lock_e            lock_d [NLANES];
  logic [W-1:0]     mm     [NLANES];
  logic [W-1:0]     mm_q   [NLANES];
  logic             s1_valid_q;
  logic [CNT_W-1:0] err_q, total_q, err_inc, tot_inc;
  logic [N+W-1:0]   ext;
  logic             pred;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // History is kept in time order: ext[N+j] is word bit j, ext[N-1] the bit just before it.
  always_comb begin
    ext  = '0;
    pred = 1'b0;
    for (int l = 0; l < NLANES; l++) begin
      ext = {bus.rx_bits[l*W +: W], hist_q[l]};
      for (int j = 0; j < W; j++) begin
        pred = 1'b0;
        for (int k = 0; k < N; k++) pred = pred ^ (bus.eqn[k] & ext[N+j-k-1]);
        mm[l][j] = (fill_q[l] == FillFull) & (ext[N+j] ^ pred);
      end
      hist_d[l] = bus.rx_valid ? ext[N+W-1 -: N] : hist_q[l];
    end
  end

  always_comb begin
    for (int l = 0; l < NLANES; l++) begin
      fill_d[l] = fill_q[l];
      lcnt_d[l] = lcnt_q[l];
      lock_d[l] = lock_q[l];
      if (mode_q == ModeReset) begin
        fill_d[l] = '0;
      end else if (bus.rx_valid) begin
        fill_d[l] = (32'(fill_q[l]) + W >= N) ? FillFull : fill_q[l] + FillW'(W);
      end
      if (!bus.lane_en[l] || mode_q == ModeReset) begin
        lcnt_d[l] = '0;
        lock_d[l] = StUnlocked;
      end else begin
        unique case (lock_q[l])
          StUnlocked: begin
            if (mode_q == ModeAlign && bus.rx_valid && fill_q[l] == FillFull) begin
              if (|mm[l]) begin
                lcnt_d[l] = '0;
              end else begin
                lcnt_d[l] = lcnt_q[l] + 1'b1;
                if (lcnt_d[l] == LockDone) lock_d[l] = StLocked;
              end
            end
          end
          StLocked: lock_d[l] = StLocked;
          default:  lock_d[l] = StUnlocked;
        endcase
      end
    end
  end

  always_comb begin
    err_inc = '0;
    tot_inc = '0;
    for (int l = 0; l < NLANES; l++) begin
      if (lock_q[l] == StLocked && bus.lane_en[l]) begin
        tot_inc = tot_inc + CNT_W'(W);
        for (int j = 0; j < W; j++) err_inc = err_inc + CNT_W'(mm_q[l][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= ModeReset;
      s1_valid_q <= 1'b0;
      err_q      <= '0;
      total_q    <= '0;
      for (int l = 0; l < NLANES; l++) begin
        hist_q[l] <= '0;
        fill_q[l] <= '0;
        lcnt_q[l] <= '0;
        lock_q[l] <= StUnlocked;
        mm_q[l]   <= '0;
      end
    end else begin
      mode_q     <= mode_e'(bus.mode);
      s1_valid_q <= bus.rx_valid;
      for (int l = 0; l < NLANES; l++) begin
        hist_q[l] <= hist_d[l];
        fill_q[l] <= fill_d[l];
        lcnt_q[l] <= lcnt_d[l];
        lock_q[l] <= lock_d[l];
        mm_q[l]   <= mm[l];
      end
      // Stage 2 keys off the current mode, so an in-flight word is dropped on leaving RUN.
      if (mode_q == ModeReset) begin
        err_q   <= '0;
        total_q <= '0;
      end else if (mode_q == ModeRun && s1_valid_q) begin
        err_q   <= sat_add(err_q, err_inc);
        total_q <= sat_add(total_q, tot_inc);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < NLANES; l++) bus.lane_locked[l] = (lock_q[l] == StLocked);
  end
  assign bus.err_bits   = err_q;
  assign bus.total_bits = total_q;
  assign bus.running    = (mode_q == ModeRun);

`ifdef PRBS_CHECKER_PER_LANE_EN
  logic [31:0] lerr_q [NLANES];
  logic [31:0] lerr_inc [NLANES];

  always_comb begin
    for (int l = 0; l < NLANES; l++) begin
      lerr_inc[l] = '0;
      if (lock_q[l] == StLocked && bus.lane_en[l]) begin
        for (int j = 0; j < W; j++) lerr_inc[l] = lerr_inc[l] + 32'(mm_q[l][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < NLANES; l++) begin
      if (rst || mode_q == ModeReset) begin
        lerr_q[l] <= '0;
      end else if (mode_q == ModeRun && s1_valid_q) begin
        lerr_q[l] <= ({1'b0, lerr_q[l]} + {1'b0, lerr_inc[l]} > 33'hFFFF_FFFF) ? '1
                   : lerr_q[l] + lerr_inc[l];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < NLANES; l++) bus.lane_err_bits[l*32 +: 32] = lerr_q[l];
  end
`endif
endmodule

// File: tb/tb_prbs_checker_multilane.sv
// Scoreboard bench: a 64-bit checker plus a 10-bit-counter copy that exercises saturation.
module tb_prbs_checker_multilane;
  localparam int unsigned N = 32, W = 16, NL = 4, CW = 64, SW = 10;
  localparam logic [1:0] MReset = 2'd0, MAlign = 2'd1, MRun = 2'd2, MFreeze = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs_checker_multilane_if #(.N(N), .W(W), .NLANES(NL), .CNT_W(CW)) bus ();
  prbs_checker_multilane_if #(.N(N), .W(W), .NLANES(NL), .CNT_W(SW)) sbus ();

  assign sbus.mode     = bus.mode;
  assign sbus.eqn      = bus.eqn;
  assign sbus.lane_en  = bus.lane_en;
  assign sbus.rx_valid = bus.rx_valid;
  assign sbus.rx_bits  = bus.rx_bits;

  prbs_checker_multilane #(.N(N), .W(W), .NLANES(NL), .LOCK_CYC(8), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  prbs_checker_multilane #(.N(N), .W(W), .NLANES(NL), .LOCK_CYC(8), .CNT_W(SW)) sat_dut (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  typedef struct {
    int unsigned   due;
    logic [95:0]   name;
    logic [3:0]    locked;
    logic          run;
    logic [63:0]   err;
    logic [63:0]   tot;
    logic [9:0]    serr;
    logic [9:0]    stot;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [6:0]  gen [NL];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (bus.lane_locked !== mon_e.locked || bus.running !== mon_e.run ||
          bus.err_bits !== mon_e.err || bus.total_bits !== mon_e.tot ||
          sbus.err_bits !== mon_e.serr || sbus.total_bits !== mon_e.stot) begin
        n_bad++;
        $display("FAIL %0s: got locked=%h run=%b err=%0d tot=%0d serr=%0d stot=%0d; want locked=%h run=%b err=%0d tot=%0d serr=%0d stot=%0d",
                 mon_e.name, bus.lane_locked, bus.running, bus.err_bits, bus.total_bits,
                 sbus.err_bits, sbus.total_bits, mon_e.locked, mon_e.run, mon_e.err,
                 mon_e.tot, mon_e.serr, mon_e.stot);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [95:0] nm, input logic [3:0] lk, input logic rn,
                      input logic [63:0] er, input logic [63:0] to,
                      input logic [9:0] se, input logic [9:0] st);
    exp_t e;
    e.due = cyc; e.name = nm; e.locked = lk; e.run = rn;
    e.err = er; e.tot = to; e.serr = se; e.stot = st;
    sb.push_back(e);
  endtask

  task automatic set_mode(input logic [1:0] m);
    gap(3);
    bus.mode = m;
    gap(3);
  endtask

  // PRBS7 words per lane; rnd/inv select random or complemented lanes, one optional bit flip.
  task automatic words(input int n, input logic [3:0] rnd, input logic [3:0] inv,
                       input int flip_at, input int flip_lane, input int flip_bit);
    logic [NL*W-1:0] v;
    logic            b;
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < NL; l++) begin
        for (int j = 0; j < W; j++) begin
          b = gen[l][5] ^ gen[l][6];
          gen[l] = {gen[l][5:0], b};
          if (rnd[l]) b = 1'($urandom);
          if (inv[l]) b = ~b;
          if (i == flip_at && l == flip_lane && j == flip_bit) b = ~b;
          v[l*W+j] = b;
        end
      end
      bus.rx_valid = 1'b1;
      bus.rx_bits  = v;
      tick();
    end
    bus.rx_valid = 1'b0;
    bus.rx_bits  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    gen[0] = 7'h01; gen[1] = 7'h15; gen[2] = 7'h3a; gen[3] = 7'h7f;
    rst = 1'b1;
    bus.mode = MReset; bus.eqn = 32'h0000_0060; bus.lane_en = 4'hF;
    bus.rx_valid = 1'b0; bus.rx_bits = '0;
    gap(3);
    rst = 1'b0;
    tick();
    push("reset", 4'h0, 1'b0, 0, 0, 0, 0);

    // Clean lanes: align, run, freeze, run with a single flip, back to align.
    set_mode(MAlign);
    words(20, 4'h0, 4'h0, -1, 0, 0);
    gap(3);
    push("align_lock", 4'hF, 1'b0, 0, 0, 0, 0);
    set_mode(MRun);
    words(50, 4'h0, 4'h0, -1, 0, 0);
    gap(3);
    push("run50", 4'hF, 1'b1, 0, 3200, 0, 1023);
    set_mode(MFreeze);
    for (int i = 0; i < 30; i++) begin
      words(1, 4'h0, 4'h0, -1, 0, 0);
      push("freeze", 4'hF, 1'b0, 0, 3200, 0, 1023);
    end
    set_mode(MRun);
    words(50, 4'h0, 4'h0, 10, 2, 3);
    gap(3);
    push("run_flip", 4'hF, 1'b1, 3, 6400, 3, 1023);
    set_mode(MAlign);
    words(10, 4'h0, 4'h0, -1, 0, 0);
    gap(3);
    push("run2align", 4'hF, 1'b0, 3, 6400, 3, 1023);

    // Reset asserted while running with a valid word on the bus.
    set_mode(MRun);
    words(5, 4'h0, 4'h0, -1, 0, 0);
    gap(3);
    push("run_more", 4'hF, 1'b1, 3, 6720, 3, 1023);
    bus.rx_valid = 1'b1;
    bus.rx_bits  = '1;
    rst = 1'b1;
    tick();
    push("rst_mid", 4'h0, 1'b0, 0, 0, 0, 0);
    bus.mode = MReset;
    bus.rx_valid = 1'b0;
    tick();
    rst = 1'b0;
    gap(2);

    // Only lanes 0-1 enabled; disabled lane 2 carries random data.
    bus.lane_en = 4'b0011;
    set_mode(MAlign);
    words(20, 4'b0100, 4'h0, -1, 0, 0);
    gap(3);
    push("en_align", 4'b0011, 1'b0, 0, 0, 0, 0);
    set_mode(MRun);
    words(100, 4'b0100, 4'h0, -1, 0, 0);
    gap(3);
    push("en_run", 4'b0011, 1'b1, 0, 3200, 0, 1023);
    set_mode(MReset);
    push("mode_reset", 4'h0, 1'b0, 0, 0, 0, 0);

    // Lane 1 random throughout: never locks, contributes nothing.
    bus.lane_en = 4'hF;
    set_mode(MAlign);
    words(20, 4'b0010, 4'h0, -1, 0, 0);
    gap(3);
    push("rnd_align", 4'b1101, 1'b0, 0, 0, 0, 0);
    set_mode(MRun);
    words(100, 4'b0010, 4'h0, -1, 0, 0);
    gap(3);
    push("rnd_run", 4'b1101, 1'b1, 0, 4800, 0, 1023);

    // 20 complemented words on every lane: 320 mismatches per lane, saturating the 10-bit copy.
    set_mode(MReset);
    set_mode(MAlign);
    words(20, 4'h0, 4'h0, -1, 0, 0);
    set_mode(MRun);
    words(20, 4'h0, 4'hF, -1, 0, 0);
    words(10, 4'h0, 4'h0, -1, 0, 0);
    gap(3);
    push("saturate", 4'hF, 1'b1, 1280, 1920, 1023, 1023);

    gap(5);
    if (sb.size() != 0) begin
      $display("FAIL leftover: got %0d unchecked entries, want 0", sb.size());
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
